// File: rtl/memwb_stage_pkg.sv
// Shared widths, the MEM-stage bundle and write-back selection helpers for memwb_stage.
// Optional bypass outputs are enabled with the MEMWB_FWD_EN macro.
`ifndef MEMWB_STAGE_DEFINES
`define MEMWB_STAGE_DEFINES
`define DWIDTH 32
`define AWIDTH 5
`define PC_WIDTH 32
`define RA_REG 5'd31
`endif

package memwb_stage_pkg;

   localparam int unsigned DW = `DWIDTH;
   localparam int unsigned AW = `AWIDTH;
   localparam int unsigned PW = `PC_WIDTH;

   // Control/data captured by the MEM sub-stage.
   typedef struct packed {
      logic [DW-1:0] alu_value;
      logic [PW-1:0] ra;
      logic [AW-1:0] addr_rd;
      logic          reg_wr;
      logic          memtoreg;
      logic          jal;
   } mem_bundle_t;

   function automatic logic [AW-1:0] wb_addr(input mem_bundle_t b);
      return b.jal ? `RA_REG : b.addr_rd;
   endfunction

   function automatic logic [DW-1:0] wb_data(input mem_bundle_t b, input logic [DW-1:0] rdata);
      if (b.jal)
         return DW'(b.ra);
      else if (b.memtoreg)
         return rdata;
      else
         return b.alu_value;
   endfunction

   // Register write enable before the valid qualifier; $0 never writes.
   function automatic logic wb_en(input mem_bundle_t b);
      return (b.reg_wr | b.jal) & (wb_addr(b) != AW'(0));
   endfunction

endpackage

// File: rtl/memwb_stage_if.sv
// Execute-to-MEM input bundle and write-back outputs of memwb_stage.
// MEMWB_FWD_EN adds the execute-stage bypass signals.
interface memwb_stage_if;
   import memwb_stage_pkg::*;

   logic          mw_i_ce;
   logic [DW-1:0] mw_i_alu_value;
   logic [DW-1:0] mw_i_data_rt;
   logic [AW-1:0] mw_i_addr_rd;
   logic          mw_i_reg_wr;
   logic          mw_i_memwrite;
   logic          mw_i_memtoreg;
   logic          mw_i_jal;
   logic [PW-1:0] mw_i_ra;

   logic [DW-1:0] mw_o_data_rd;
   logic [AW-1:0] mw_o_addr_rd;
   logic          mw_o_reg_wr;
   logic          mw_o_ce;
`ifdef MEMWB_FWD_EN
   logic          mw_o_fwd_valid;
   logic [AW-1:0] mw_o_fwd_addr;
   logic [DW-1:0] mw_o_fwd_data;
`endif

   modport master (
      output mw_i_ce, mw_i_alu_value, mw_i_data_rt, mw_i_addr_rd, mw_i_reg_wr,
             mw_i_memwrite, mw_i_memtoreg, mw_i_jal, mw_i_ra,
`ifdef MEMWB_FWD_EN
      input  mw_o_fwd_valid, mw_o_fwd_addr, mw_o_fwd_data,
`endif
      input  mw_o_data_rd, mw_o_addr_rd, mw_o_reg_wr, mw_o_ce
   );

   modport slave (
      input  mw_i_ce, mw_i_alu_value, mw_i_data_rt, mw_i_addr_rd, mw_i_reg_wr,
             mw_i_memwrite, mw_i_memtoreg, mw_i_jal, mw_i_ra,
`ifdef MEMWB_FWD_EN
      output mw_o_fwd_valid, mw_o_fwd_addr, mw_o_fwd_data,
`endif
      output mw_o_data_rd, mw_o_addr_rd, mw_o_reg_wr, mw_o_ce
   );

endinterface

// File: rtl/memwb_stage_dmem.sv
// Single-port synchronous data RAM: write when we, otherwise registered read.
module memwb_stage_dmem #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned DW    = 32,
   localparam int unsigned IW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
      else
         rdata <= mem[addr];
   end

endmodule

// File: rtl/memwb_stage.sv
// MIPS memory-access / write-back stage: MEM sub-stage (dmem access) then WB register.
// Define MEMWB_FWD_EN to expose the MEM-stage bypass outputs.
module memwb_stage
   import memwb_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 256
) (
   input  logic          mw_clk,
   input  logic          mw_rst,
   memwb_stage_if.slave  mw
);

   localparam int unsigned IW = $clog2(DEPTH);

   mem_bundle_t   in_b_c;
   mem_bundle_t   m_b;
   logic          m_v;
   logic [DW-1:0] m_rdata;
   logic          dmem_we_c;

   // Stores never request a register write, whatever the control bundle says.
   always_comb begin
      in_b_c           = '0;
      in_b_c.alu_value = mw.mw_i_alu_value;
      in_b_c.ra        = mw.mw_i_ra;
      in_b_c.addr_rd   = mw.mw_i_addr_rd;
      in_b_c.reg_wr    = mw.mw_i_reg_wr & ~mw.mw_i_memwrite;
      in_b_c.memtoreg  = mw.mw_i_memtoreg;
      in_b_c.jal       = mw.mw_i_jal;
   end

   assign dmem_we_c = ~mw_rst & mw.mw_i_ce & mw.mw_i_memwrite;

   memwb_stage_dmem #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_dmem (
      .clk   (mw_clk),
      .we    (dmem_we_c),
      .addr  (mw.mw_i_alu_value[IW+1:2]),
      .wdata (mw.mw_i_data_rt),
      .rdata (m_rdata)
   );

   // MEM bundle is datapath only; it holds through bubbles and needs no reset.
   always_ff @(posedge mw_clk) begin
      if (mw.mw_i_ce)
         m_b <= in_b_c;
   end

   // Valid chain and write-back register.
   always_ff @(posedge mw_clk) begin
      if (mw_rst) begin
         m_v             <= 1'b0;
         mw.mw_o_ce      <= 1'b0;
         mw.mw_o_data_rd <= '0;
         mw.mw_o_addr_rd <= '0;
         mw.mw_o_reg_wr  <= 1'b0;
      end else begin
         m_v             <= mw.mw_i_ce;
         mw.mw_o_ce      <= m_v;
         mw.mw_o_data_rd <= wb_data(m_b, m_rdata);
         mw.mw_o_addr_rd <= wb_addr(m_b);
         mw.mw_o_reg_wr  <= m_v & wb_en(m_b);
      end
   end

`ifdef MEMWB_FWD_EN
   // Bypass view of the MEM slot; loads are not ready yet and never forward.
   always_ff @(posedge mw_clk) begin
      if (mw_rst) begin
         mw.mw_o_fwd_valid <= 1'b0;
         mw.mw_o_fwd_addr  <= '0;
         mw.mw_o_fwd_data  <= '0;
      end else begin
         mw.mw_o_fwd_valid <= mw.mw_i_ce & wb_en(in_b_c) & ~in_b_c.memtoreg;
         if (mw.mw_i_ce) begin
            mw.mw_o_fwd_addr <= wb_addr(in_b_c);
            mw.mw_o_fwd_data <= in_b_c.jal ? DW'(in_b_c.ra) : in_b_c.alu_value;
         end
      end
   end
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// Scoreboard bench for memwb_stage: expected write-back slots queued at issue, checked on output.
module tb_memwb_stage;
   import memwb_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          tests = 0;
   int          fails = 0;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   memwb_stage_if bus ();

   memwb_stage #(.DEPTH(256)) dut (
      .mw_clk (clk),
      .mw_rst (rst),
      .mw     (bus)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        rw;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [256];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic drive_idle();
      bus.mw_i_ce        = 1'b0;
      bus.mw_i_alu_value = '0;
      bus.mw_i_data_rt   = '0;
      bus.mw_i_addr_rd   = '0;
      bus.mw_i_reg_wr    = 1'b0;
      bus.mw_i_memwrite  = 1'b0;
      bus.mw_i_memtoreg  = 1'b0;
      bus.mw_i_jal       = 1'b0;
      bus.mw_i_ra        = '0;
   endtask

   task automatic idle(input int n);
      drive_idle();
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one instruction for one edge and queue its expected write-back slot.
   task automatic issue(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd,
                        input logic rw, input logic ms, input logic mr, input logic j,
                        input logic [31:0] ra);
      exp_t       e;
      logic [7:0] idx;
      idx = alu[9:2];
      bus.mw_i_ce        = 1'b1;
      bus.mw_i_alu_value = alu;
      bus.mw_i_data_rt   = rt;
      bus.mw_i_addr_rd   = rd;
      bus.mw_i_reg_wr    = rw;
      bus.mw_i_memwrite  = ms;
      bus.mw_i_memtoreg  = mr;
      bus.mw_i_jal       = j;
      bus.mw_i_ra        = ra;
      if (ms) model[idx] = rt;
      e.data = j ? ra : (mr ? model[idx] : alu);
      e.addr = j ? 5'd31 : rd;
      e.rw   = ~ms & (rw | j) & (e.addr != 5'd0);
      @(posedge clk);
      #1;
      e.cyc = cyc;
      sb.push_back(e);
      bus.mw_i_ce = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ce"},   32'(bus.mw_o_ce), 32'd0);
      check({tag, "_rw"},   32'(bus.mw_o_reg_wr), 32'd0);
      check({tag, "_data"}, bus.mw_o_data_rd, 32'd0);
      check({tag, "_addr"}, 32'(bus.mw_o_addr_rd), 32'd0);
   endtask

   // Output monitor: every valid slot must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mw_o_ce) begin
            if (sb.size() == 0) begin
               check("spurious_slot", 32'(bus.mw_o_ce), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("wb_data", bus.mw_o_data_rd, e.data);
               check("wb_addr", 32'(bus.mw_o_addr_rd), 32'(e.addr));
               check("wb_rw",   32'(bus.mw_o_reg_wr), 32'(e.rw));
               check("latency", 32'(cyc - e.cyc), 32'd1);
            end
         end else begin
            check("rw_without_ce", 32'(bus.mw_o_reg_wr), 32'd0);
         end
      end
   end

   initial begin
      drive_idle();
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check_outputs_zero("reset0");
      rst = 1'b0;

      // Known word at 0x40, then a store held through a 3-cycle reset must be dropped.
      issue(32'h40, 32'h1111_1111, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      rst = 1'b1;
      bus.mw_i_ce        = 1'b1;
      bus.mw_i_memwrite  = 1'b1;
      bus.mw_i_alu_value = 32'h40;
      bus.mw_i_data_rt   = 32'h2222_2222;
      bus.mw_i_addr_rd   = 5'd3;
      bus.mw_i_reg_wr    = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check_outputs_zero("reset1");
      sb.delete();
      drive_idle();
      rst = 1'b0;
      idle(1);
      issue(32'h40, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

      // ALU op, store/load forwarding through memory, jal, $0 suppression.
      issue(32'h0000_002A, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      issue(32'h10, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      issue(32'h10, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      issue(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0104);
      issue(32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      // Bubbles in the input stream keep order and produce no slots.
      issue(32'hA1, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      idle(1);
      issue(32'hA2, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      idle(2);
      issue(32'hA3, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

      // Index wrap above the RAM size and ignored byte-offset bits.
      issue(32'h420, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      issue(32'h23, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

`ifdef MEMWB_FWD_EN
      issue(32'h77, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      check("fwd_valid_alu", 32'(bus.mw_o_fwd_valid), 32'd1);
      check("fwd_addr_alu",  32'(bus.mw_o_fwd_addr), 32'd5);
      check("fwd_data_alu",  bus.mw_o_fwd_data, 32'h77);
      issue(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      check("fwd_valid_load", 32'(bus.mw_o_fwd_valid), 32'd0);
`endif

      // Random mix over a pre-initialised window of 16 words.
      for (int i = 0; i < 16; i++)
         issue(32'(i * 4), $urandom, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         int          kind;
         a    = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
         kind = $urandom_range(0, 4);
         case (kind)
            0: issue(a, $urandom, 5'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0, 32'h0);
            1: issue(a, 32'h0, 5'($urandom), 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            2: issue(32'h0, 32'h0, 5'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, $urandom);
            3: idle(1);
            default: issue($urandom, 32'h0, 5'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 32'h0);
         endcase
      end

      idle(3);
      for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
      check("drain", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/memwb_stage.md
# memwb_stage

Memory-access and write-back stage of the five-stage MIPS pipeline: the producer end of the decoder's register-file write port. It takes the execute stage's result and control bundle, performs data-memory loads/stores in an internal word-addressed RAM, and returns the write-back triple (data, destination register, write enable) to the decoder stage. It closes the pipeline loop that the decoder stage opens.

## Interface
- DEPTH, 256: data-memory words (power of two)
- mw_clk  in  1  clock, rising edge
- mw_rst  in  1  synchronous, active-high reset
- mw_i_ce  in  1  execute result valid this cycle
- mw_i_alu_value  in  `DWIDTH  ALU result / memory byte address
- mw_i_data_rt  in  `DWIDTH  store data
- mw_i_addr_rd  in  `AWIDTH  destination register
- mw_i_reg_wr  in  1  instruction writes a register
- mw_i_memwrite  in  1  store
- mw_i_memtoreg  in  1  load (write-back takes memory data)
- mw_i_jal  in  1  jal: write return address to $31
- mw_i_ra  in  `PC_WIDTH  return address (PC+4)
- mw_o_data_rd  out  `DWIDTH  write-back data → ds_i_data_rd
- mw_o_addr_rd  out  `AWIDTH  write-back register → ds_i_addr_rd
- mw_o_reg_wr  out  1  write-back enable → ds_i_reg_wr
- mw_o_ce  out  1  write-back slot valid

## Operation
- Two registered sub-stages: MEM (valid bit m_v plus captured bundle) and WB (valid bit w_v plus result).
- Edge N with mw_i_ce=1: MEM captures bundle; if mw_i_memwrite, dmem[mw_i_alu_value[log2(DEPTH)+1:2]] <= mw_i_data_rt; otherwise the same word is read synchronously into the MEM read register.
- mw_i_ce=0 at an edge: m_v<=0, no memory write, bundle holds.
- Edge N+1: WB captures from MEM: data = ra (zero-extended) if jal, else read data if memtoreg, else alu_value; addr = 5'd31 if jal, else addr_rd; reg_wr = m_v & (reg_wr|jal) & (addr≠0).
- Stores never assert mw_o_reg_wr. Writes to $0 are suppressed here, not left to the register file.
- Address bits [1:0] ignored (word access only); upper bits beyond the index wrap modulo DEPTH.
- A load issued the cycle after a store to the same word returns the new data (array written at edge N, read at edge N+1).
- No back-pressure: the stage accepts one instruction per cycle unconditionally.

## Timing
- Latency 2: inputs sampled at edge N → outputs valid after edge N+1 → register file commits at edge N+2.
- Throughput 1 per cycle; all outputs registered.
- Reset (edge with mw_rst=1): m_v=w_v=0, mw_o_data_rd=0, mw_o_addr_rd=0, mw_o_reg_wr=0, mw_o_ce=0; memory contents not cleared; a store presented during reset is dropped.
- Reset mid-flight discards both in-flight instructions; first valid output occurs 2 edges after the first mw_i_ce=1 following reset release.
- mw_o_reg_wr is never 1 while mw_o_ce=0.

## Configuration
- MEMWB_FWD_EN defined: adds outputs mw_o_fwd_valid (1), mw_o_fwd_addr (`AWIDTH), mw_o_fwd_data (`DWIDTH), driven from the MEM register for the execute-stage bypass mux; fwd_valid = m_v & reg_wr & ~memtoreg & addr≠0 (jal forwards ra to $31); loads never forward. Reset value 0.
- Undefined: those ports and their logic do not exist; hazards are handled by software NOPs.

## Structure
- Shared defines header: `DWIDTH, `AWIDTH, `PC_WIDTH, and new `RA_REG (5'd31).
- One sub-module: dmem (single-port synchronous RAM: clk, we, addr, wdata, rdata); write-back mux and valid chain in memwb_stage.

## Test plan
- Reset: hold mw_rst 3 cycles with mw_i_ce=1 → all outputs 0, no store visible afterwards.
- ALU op: alu_value=0x0000_002A, addr_rd=8, reg_wr=1 → two edges later data_rd=0x2A, addr_rd=8, reg_wr=1, ce=1.
- Store then load: sw 0xDEADBEEF to addr 0x10, next cycle lw addr 0x10 → rd=9 with 0xDEADBEEF; store slot shows reg_wr=0.
- jal: jal=1, ra=0x0000_0104 → data_rd=0x104, addr_rd=31, reg_wr=1.
- $0 write: addr_rd=0, reg_wr=1 → reg_wr=0, ce=1; back-to-back ops with gaps in mw_i_ce preserve order and drop bubbles.
- MEMWB_FWD_EN: ALU op to rd=5 → fwd_valid=1, fwd_addr=5 during MEM cycle; load to rd=5 → fwd_valid=0.
